// File: rtl/min_tree_gamma_if.sv
// min_tree_gamma_if: spike inputs and winner outputs of the temporal-min unit.
// Latency: none, wires only.
// Backpressure: none; master drives in_pulse, slave (the unit) drives the rest.
// Optional: MIN_TIE_FLAG_EN adds the tie signal.
`timescale 1ns/1ps
interface min_tree_gamma_if #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16
);
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int TW    = $clog2(GAMMA_CYCLE_WIDTH);

  logic [N_INPUTS-1:0] in_pulse;
  logic                gamma_start;
  logic                y;
  logic                valid;
  logic [IDX_W-1:0]    winner_idx;
  logic [TW-1:0]       arrival_time;
`ifdef MIN_TIE_FLAG_EN
  logic                tie;

  modport master (output in_pulse,
                  input  gamma_start, y, valid, winner_idx, arrival_time, tie);
  modport slave  (input  in_pulse,
                  output gamma_start, y, valid, winner_idx, arrival_time, tie);
`else
  modport master (output in_pulse,
                  input  gamma_start, y, valid, winner_idx, arrival_time);
  modport slave  (input  in_pulse,
                  output gamma_start, y, valid, winner_idx, arrival_time);
`endif
endinterface

// File: rtl/min_tree_gamma.sv
// min_tree_gamma: N-input first-arrival (temporal min) unit, one fire per gamma cycle.
// Latency: winner registered at end of arrival slot T; y high T+1..T+PULSE_WIDTH.
// Backpressure: none; edges in the last slot or after a win are dropped.
// Optional: MIN_TIE_FLAG_EN adds the tie output.
`timescale 1ns/1ps
module min_tree_gamma #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input logic             aclk,
  input logic             grst,
  min_tree_gamma_if.slave bus
);
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int TW    = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int PCW   = $clog2(PULSE_WIDTH + 1);

  if (N_INPUTS < 2) begin : g_chk_n
    $error("min_tree_gamma: N_INPUTS must be >= 2");
  end
  if (GAMMA_CYCLE_WIDTH < 4) begin : g_chk_gcw
    $error("min_tree_gamma: GAMMA_CYCLE_WIDTH must be >= 4");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH >= GAMMA_CYCLE_WIDTH) begin : g_chk_pw
    $error("min_tree_gamma: PULSE_WIDTH must be in [1, GAMMA_CYCLE_WIDTH-1]");
  end

  typedef enum logic [1:0] {IDLE, FIRE, DONE} state_t;

  state_t              state;
  logic [TW-1:0]       g_cnt;
  logic [N_INPUTS-1:0] in_prev;
  logic [N_INPUTS-1:0] edges;
  logic [PCW-1:0]      pcnt;
  logic                y_q;
  logic                valid_q;
  logic [IDX_W-1:0]    win_q;
  logic [TW-1:0]       arr_q;
  logic [IDX_W-1:0]    win_idx;
  logic                last_slot;
  logic                accept;
`ifdef MIN_TIE_FLAG_EN
  logic                tie_q;
  logic                multi;
`endif

  // Rising-edge detect, lowest-index priority pick and accept window.
  always_comb begin
    edges     = bus.in_pulse & ~in_prev;
    last_slot = (g_cnt == TW'(GAMMA_CYCLE_WIDTH - 1));
    accept    = (state == IDLE) && (g_cnt <= TW'(GAMMA_CYCLE_WIDTH - 2)) && (|edges);
    win_idx   = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (edges[i]) win_idx = IDX_W'(i);
    end
`ifdef MIN_TIE_FLAG_EN
    // More than one bit set means a tie.
    multi = |(edges & (edges - N_INPUTS'(1)));
`endif
  end

  // Gamma counter, edge history, FSM and registered outputs; the boundary overrides all states.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      g_cnt   <= '0;
      in_prev <= '0;
      state   <= IDLE;
      pcnt    <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      win_q   <= '0;
      arr_q   <= '0;
`ifdef MIN_TIE_FLAG_EN
      tie_q   <= 1'b0;
`endif
    end else begin
      in_prev <= bus.in_pulse;
      if (last_slot) begin
        // Truncate any running pulse; winner_idx/arrival_time keep their values.
        g_cnt   <= '0;
        state   <= IDLE;
        pcnt    <= '0;
        y_q     <= 1'b0;
        valid_q <= 1'b0;
`ifdef MIN_TIE_FLAG_EN
        tie_q   <= 1'b0;
`endif
      end else begin
        g_cnt <= g_cnt + TW'(1);
        case (state)
          IDLE: begin
            if (accept) begin
              win_q   <= win_idx;
              arr_q   <= g_cnt;
              valid_q <= 1'b1;
              y_q     <= 1'b1;
              pcnt    <= PCW'(PULSE_WIDTH);
`ifdef MIN_TIE_FLAG_EN
              tie_q   <= multi;
`endif
              state   <= FIRE;
            end
          end
          FIRE: begin
            pcnt <= pcnt - PCW'(1);
            if (pcnt == PCW'(1)) begin
              y_q   <= 1'b0;
              state <= DONE;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.gamma_start  = (g_cnt == '0);
  assign bus.y            = y_q;
  assign bus.valid        = valid_q;
  assign bus.winner_idx   = win_q;
  assign bus.arrival_time = arr_q;
`ifdef MIN_TIE_FLAG_EN
  assign bus.tie          = tie_q;
`endif
endmodule

// File: tb/tb_min_tree_gamma.sv
// tb_min_tree_gamma: directed scenarios for the temporal-min unit at N=4, GCW=16, PW=8.
// Latency: expectations are per g_cnt slot, tracked by a bench-side slot counter.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_min_tree_gamma;
  logic aclk = 1'b0;
  logic grst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   slot  = 0;

  min_tree_gamma_if #(.N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16)) bus ();

  min_tree_gamma #(.N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8)) dut (
    .aclk (aclk),
    .grst (grst),
    .bus  (bus)
  );

  always #5 aclk = ~aclk;

  // Bench's own notion of the current gamma slot.
  always @(posedge aclk or negedge grst) begin
    if (!grst) slot <= 0;
    else       slot <= (slot == 15) ? 0 : slot + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to the negedge inside the cycle whose slot is s.
  task automatic goto_slot(input int s);
    int n;
    n = 0;
    @(negedge aclk);
    while (slot != s && n < 40) begin
      @(negedge aclk);
      n++;
    end
    if (slot != s) begin
      total++; bad++;
      $display("FAIL goto_slot: got slot %0d, want %0d", slot, s);
    end
  endtask

  task automatic test_reset();
    bus.in_pulse = 4'b0000;
    grst = 1'b0;
    repeat (3) @(negedge aclk);
    total++; if (bus.y !== 1'b0) begin bad++; $display("FAIL reset_y: got %b want 0", bus.y); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    total++; if (bus.winner_idx !== 2'd0) begin bad++; $display("FAIL reset_winner: got %0d want 0", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd0) begin bad++; $display("FAIL reset_arrival: got %0d want 0", bus.arrival_time); end
    total++; if (bus.gamma_start !== 1'b1) begin bad++; $display("FAIL reset_gamma_start: got %b want 1", bus.gamma_start); end
`ifdef MIN_TIE_FLAG_EN
    total++; if (bus.tie !== 1'b0) begin bad++; $display("FAIL reset_tie: got %b want 0", bus.tie); end
`endif
    grst = 1'b1;
    #1;
    total++; if (bus.gamma_start !== 1'b1) begin bad++; $display("FAIL release_gamma_start: got %b want 1", bus.gamma_start); end
    @(negedge aclk);
    total++; if (bus.gamma_start !== 1'b0) begin bad++; $display("FAIL slot1_gamma_start: got %b want 0", bus.gamma_start); end
  endtask

  task automatic test_single();
    goto_slot(3);
    bus.in_pulse = 4'b0100;
    for (int k = 0; k < 14; k++) begin
      logic ey, ev;
      if (k > 0) @(negedge aclk);
      ey = (slot >= 4 && slot <= 11);
      ev = (slot >= 4);
      total++; if (bus.y !== ey) begin bad++; $display("FAIL single_y slot %0d: got %b want %b", slot, bus.y, ey); end
      total++; if (bus.valid !== ev) begin bad++; $display("FAIL single_valid slot %0d: got %b want %b", slot, bus.valid, ev); end
    end
    total++; if (bus.winner_idx !== 2'd2) begin bad++; $display("FAIL single_winner: got %0d want 2", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd3) begin bad++; $display("FAIL single_arrival: got %0d want 3", bus.arrival_time); end
    total++; if (bus.gamma_start !== 1'b1) begin bad++; $display("FAIL single_gamma_start: got %b want 1", bus.gamma_start); end
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_tie();
    goto_slot(5);
    bus.in_pulse = 4'b1010;
    @(negedge aclk);
    total++; if (bus.winner_idx !== 2'd1) begin bad++; $display("FAIL tie_winner: got %0d want 1", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd5) begin bad++; $display("FAIL tie_arrival: got %0d want 5", bus.arrival_time); end
    total++; if (bus.y !== 1'b1) begin bad++; $display("FAIL tie_y: got %b want 1", bus.y); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL tie_valid: got %b want 1", bus.valid); end
`ifdef MIN_TIE_FLAG_EN
    total++; if (bus.tie !== 1'b1) begin bad++; $display("FAIL tie_flag: got %b want 1", bus.tie); end
`endif
    goto_slot(0);
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL tie_boundary_valid: got %b want 0", bus.valid); end
    total++; if (bus.y !== 1'b0) begin bad++; $display("FAIL tie_boundary_y: got %b want 0", bus.y); end
`ifdef MIN_TIE_FLAG_EN
    total++; if (bus.tie !== 1'b0) begin bad++; $display("FAIL tie_boundary_flag: got %b want 0", bus.tie); end
`endif
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_late_loser();
    goto_slot(2);
    bus.in_pulse = 4'b1000;
    for (int k = 0; k < 15; k++) begin
      logic ey;
      if (k > 0) @(negedge aclk);
      if (slot == 6) bus.in_pulse = 4'b1001;
      ey = (slot >= 3 && slot <= 10);
      total++; if (bus.y !== ey) begin bad++; $display("FAIL late_y slot %0d: got %b want %b", slot, bus.y, ey); end
    end
    total++; if (bus.winner_idx !== 2'd3) begin bad++; $display("FAIL late_winner: got %0d want 3", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd2) begin bad++; $display("FAIL late_arrival: got %0d want 2", bus.arrival_time); end
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_truncation();
    goto_slot(12);
    bus.in_pulse = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      logic e;
      if (k > 0) @(negedge aclk);
      e = (slot >= 13);
      total++; if (bus.y !== e) begin bad++; $display("FAIL trunc_y slot %0d: got %b want %b", slot, bus.y, e); end
      total++; if (bus.valid !== e) begin bad++; $display("FAIL trunc_valid slot %0d: got %b want %b", slot, bus.valid, e); end
    end
    total++; if (bus.winner_idx !== 2'd0) begin bad++; $display("FAIL trunc_winner: got %0d want 0", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd12) begin bad++; $display("FAIL trunc_arrival: got %0d want 12", bus.arrival_time); end
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_last_slot_drop();
    goto_slot(15);
    bus.in_pulse = 4'b0010;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge aclk);
      total++; if (bus.y !== 1'b0) begin bad++; $display("FAIL drop_y slot %0d: got %b want 0", slot, bus.y); end
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL drop_valid slot %0d: got %b want 0", slot, bus.valid); end
    end
    total++; if (bus.winner_idx !== 2'd0) begin bad++; $display("FAIL drop_winner: got %0d want 0", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd12) begin bad++; $display("FAIL drop_arrival: got %0d want 12", bus.arrival_time); end
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_reset_mid_pulse();
    goto_slot(3);
    bus.in_pulse = 4'b0100;
    goto_slot(7);
    total++; if (bus.y !== 1'b1) begin bad++; $display("FAIL mid_y_before: got %b want 1", bus.y); end
    grst = 1'b0;
    #1;
    total++; if (bus.y !== 1'b0) begin bad++; $display("FAIL mid_y_reset: got %b want 0", bus.y); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL mid_valid_reset: got %b want 0", bus.valid); end
    total++; if (bus.winner_idx !== 2'd0) begin bad++; $display("FAIL mid_winner_reset: got %0d want 0", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd0) begin bad++; $display("FAIL mid_arrival_reset: got %0d want 0", bus.arrival_time); end
    bus.in_pulse = 4'b0000;
    repeat (2) @(negedge aclk);
    grst = 1'b1;
    #1;
    total++; if (bus.gamma_start !== 1'b1) begin bad++; $display("FAIL mid_release_gamma_start: got %b want 1", bus.gamma_start); end
    goto_slot(2);
    bus.in_pulse = 4'b0010;
    for (int k = 0; k < 14; k++) begin
      logic ey, ev;
      if (k > 0) @(negedge aclk);
      ey = (slot >= 3 && slot <= 10);
      ev = (slot >= 3);
      total++; if (bus.y !== ey) begin bad++; $display("FAIL mid_new_y slot %0d: got %b want %b", slot, bus.y, ey); end
      total++; if (bus.valid !== ev) begin bad++; $display("FAIL mid_new_valid slot %0d: got %b want %b", slot, bus.valid, ev); end
    end
    total++; if (bus.winner_idx !== 2'd1) begin bad++; $display("FAIL mid_new_winner: got %0d want 1", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd2) begin bad++; $display("FAIL mid_new_arrival: got %0d want 2", bus.arrival_time); end
    bus.in_pulse = 4'b0000;
  endtask

  task automatic test_held_at_release();
    grst = 1'b0;
    bus.in_pulse = 4'b1000;
    repeat (2) @(negedge aclk);
    grst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic ey;
      @(negedge aclk);
      ey = (slot >= 1 && slot <= 8);
      total++; if (bus.y !== ey) begin bad++; $display("FAIL held_y slot %0d: got %b want %b", slot, bus.y, ey); end
    end
    total++; if (bus.winner_idx !== 2'd3) begin bad++; $display("FAIL held_winner: got %0d want 3", bus.winner_idx); end
    total++; if (bus.arrival_time !== 4'd0) begin bad++; $display("FAIL held_arrival: got %0d want 0", bus.arrival_time); end
    goto_slot(1);
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL held_no_rearm_valid: got %b want 0", bus.valid); end
    total++; if (bus.y !== 1'b0) begin bad++; $display("FAIL held_no_rearm_y: got %b want 0", bus.y); end
    bus.in_pulse = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_late_loser();
    test_truncation();
    test_last_slot_drop();
    test_reset_mid_pulse();
    test_held_at_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/min_tree_gamma.md
Name: min_tree_gamma

Overview:
- N-input temporal minimum (first-arrival) unit for race-logic columns.
- Inputs are pulse-width encoded spikes; each spike's time is its rising edge.
- Block runs its own gamma-cycle counter and fires at most once per gamma cycle.
- Output is a fixed-width pulse plus the winner channel index and the arrival time slot. Successor to the 2-input pulse-width min.

Parameters:
N_INPUTS, 4, number of input channels (>=2)
GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (>=4)
PULSE_WIDTH, 8, output pulse length in cycles (1 <= PULSE_WIDTH < GAMMA_CYCLE_WIDTH; elaboration-time check)

Ports:
aclk  input  1  clock
grst  input  1  global reset, asynchronous, active-low
in_pulse  input  N_INPUTS  input spike lines
gamma_start  output  1  high while g_cnt==0
y  output  1  min output pulse
valid  output  1  a winner has been captured this gamma cycle
winner_idx  output  max(1,$clog2(N_INPUTS))  index of winning channel
arrival_time  output  $clog2(GAMMA_CYCLE_WIDTH)  g_cnt slot of the winning edge

Behaviour:
- One clock (aclk); reset grst is asynchronous and active-low.
- Reset (grst=0, async): g_cnt=0, in_prev=0, state IDLE, pulse counter=0, y=0, valid=0, winner_idx=0, arrival_time=0. gamma_start is combinational from g_cnt, so it reads 1 during reset and in the first cycle after release.
- g_cnt: increments every cycle 0..GAMMA_CYCLE_WIDTH-1, then wraps to 0.
- Edge detect: edge[i] = in_pulse[i] & ~in_prev[i]; in_prev is registered every cycle. A line already high at reset release counts as an edge in the first cycle. A line held high across a gamma boundary does not re-arm.
- An edge is accepted only when state==IDLE and g_cnt <= GAMMA_CYCLE_WIDTH-2. Edges in the last slot are dropped.
- Simultaneous edges: the lowest index wins.
- FSM states: IDLE -> FIRE -> DONE.
  - IDLE: on the first accepted edge in cycle T, register winner_idx, arrival_time=g_cnt(T), valid=1, load pulse counter=PULSE_WIDTH; go to FIRE.
  - FIRE: y=1 from cycle T+1 for PULSE_WIDTH cycles (y is a registered output); then go to DONE.
  - DONE: ignore all edges.
- Boundary: on the clock edge ending slot g_cnt==GAMMA_CYCLE_WIDTH-1, next state is IDLE from any state. y, valid and the pulse counter clear; winner_idx and arrival_time hold their last values.
  - A pulse still running at the boundary is truncated.
  - y and valid are never high in a g_cnt==0 cycle.
  - An edge in the g_cnt==0 slot belongs to the new gamma cycle.
- Only one y pulse per gamma cycle. Later edges produce nothing.

Optional Feature:
MIN_TIE_FLAG_EN
- Defined: adds output port tie (1 bit). It registers with winner_idx and is 1 if two or more channels had accepted edges in the winning cycle. It resets to 0 and clears at the gamma boundary.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use defaults N=4, GCW=16, PW=8.
1. Single arrival: in_pulse[2] rises at g_cnt=3 -> y=1 for g_cnt 4..11; winner_idx=2; arrival_time=3; valid=1 for g_cnt 4..15, 0 at next g_cnt 0.
2. Tie: in_pulse[1] and in_pulse[3] rise at g_cnt=5 -> winner_idx=1, arrival_time=5; tie=1 when MIN_TIE_FLAG_EN is defined.
3. Late loser: in_pulse[3] rises at g_cnt=2, in_pulse[0] at g_cnt=6 -> winner_idx=3; exactly one y pulse at g_cnt 3..10; nothing from channel 0.
4. Truncation: in_pulse[0] rises at g_cnt=12 -> y=1 for g_cnt 13..15 only (3 cycles); y=0, valid=0 at next g_cnt 0; winner_idx stays 0.
5. Last-slot drop: in_pulse[1] rises at g_cnt=15 and stays high -> no y, valid=0 in this cycle and throughout the next gamma cycle (no new edge).
6. Reset mid-pulse: grst driven low at g_cnt=7 during a pulse -> y, valid, winner_idx, arrival_time go to 0 immediately. After release, g_cnt=0 and gamma_start=1, and a new arrival fires normally.
